// File: rtl/fsm_ctrl_pkg.sv
// Shared constants for the pattern scan controller: state encoding, default width
// and the detector pattern.
package fsm_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int DEFAULT_DATA_W = 16;

  // Sequence recognised by the companion detector, oldest bit in the MSB.
  localparam logic [4:0] DET_PATTERN = 5'b01010;

endpackage

// File: rtl/FSM.sv
// Moore detector for the overlapping sequence 01010; y is high for one cycle after
// the final bit. Reset is asynchronous and active-low.
module FSM (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic y
);

  localparam logic [2:0] S0 = 3'd0;  // nothing useful seen
  localparam logic [2:0] S1 = 3'd1;  // "0"
  localparam logic [2:0] S2 = 3'd2;  // "01"
  localparam logic [2:0] S3 = 3'd3;  // "010"
  localparam logic [2:0] S4 = 3'd4;  // "0101"
  localparam logic [2:0] S5 = 3'd5;  // "01010" matched

  logic [2:0] state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    case (state)
      S0: state_nxt = x ? S0 : S1;
      S1: state_nxt = x ? S2 : S1;
      S2: state_nxt = x ? S0 : S3;
      S3: state_nxt = x ? S4 : S1;
      S4: state_nxt = x ? S0 : S5;
      S5: state_nxt = x ? S4 : S1;  // overlap: "01010"+"1" ends in "0101"
      default: state_nxt = S0;
    endcase
  end

  always_comb begin
    y = (state == S5);
  end

endmodule

// File: rtl/piso_shift.sv
// Parallel-in/serial-out register, MSB first, zero-filled; load wins over shift.
// Output is the registered MSB, no backpressure.
module piso_shift #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job controller: clears the detector, shifts a word in MSB-first and counts matches.
// Latency len+3 cycles from start to done; start is ignored while busy, abort cancels.
module pattern_scan_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic              det_x,
  output logic              det_rst_n,
  input  logic              det_y
);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] len_clamped;
  logic             in_shift;
  logic             in_drain;
  logic             accept;
  logic             kill;
  logic             sr_msb;

  assign len_clamped = (len > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : len;
  assign accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign kill        = abort && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (bit_cnt == '0) ? ST_DRAIN : ST_SHIFT;
      ST_SHIFT: if (bit_cnt == CNT_W'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_CLEAR : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_shift = 1'b0;
    in_drain = 1'b0;
    case (state)
      ST_CLEAR: busy = 1'b1;
      ST_SHIFT: begin
        busy     = 1'b1;
        in_shift = 1'b1;
      end
      ST_DRAIN: begin
        busy     = 1'b1;
        in_drain = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
    det_x = in_shift & sr_msb;
  end

  piso_shift #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (in_shift),
    .din   (data),
    .msb   (sr_msb)
  );

  // Detector reset is registered so it is glitch-free: low in CLEAR and after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      match_count <= '0;
      det_rst_n   <= 1'b0;
    end else begin
      det_rst_n <= !(accept || kill);
      if (accept) begin
        bit_cnt <= len_clamped;
      end else if (in_shift) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (accept || kill) begin
        match_count <= '0;
      end else if ((in_shift || in_drain) && det_y) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl driving a real FSM detector; expectations come from a
// bit-window model of the job word.
module tb_pattern_scan_ctrl;
  import fsm_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] data;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [4:0]  match_count;
  logic        det_x;
  logic        det_rst_n;
  logic        det_y;

  int checks = 0;
  int errors = 0;

  pattern_scan_ctrl #(.DATA_W(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .data        (data),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .det_x       (det_x),
    .det_rst_n   (det_rst_n),
    .det_y       (det_y)
  );

  FSM u_det (
    .clk   (clk),
    .rst_n (det_rst_n),
    .x     (det_x),
    .y     (det_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Serial stream the detector should see: the first L word bits, then the DRAIN zero.
  function automatic logic [63:0] exp_stream(input logic [15:0] d, input int L);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < L; k++) s = {s[62:0], d[15-k]};
    return {s[62:0], 1'b0};
  endfunction

  // Count every 5-bit window of the sent bits that equals the pattern (overlaps allowed).
  function automatic int ref_count(input logic [15:0] d, input int L);
    int n;
    logic [4:0] w;
    n = 0;
    for (int k = 4; k < L; k++) begin
      w = d[19-k -: 5];
      if (w == DET_PATTERN) n++;
    end
    return n;
  endfunction

  // Called in cycle 1 (just after the accepting edge); follows the job to done.
  task automatic observe(input int start_last, output int done_cyc, output logic [63:0] xs,
                         output int lows, output logic [4:0] mc, output logic b1);
    done_cyc = -1;
    xs       = '0;
    lows     = 0;
    mc       = '0;
    b1       = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) b1 = busy;
      if (!det_rst_n) lows++;
      start = (c <= start_last);
      if (done) begin
        done_cyc = c;
        mc       = match_count;
        break;
      end
      if (c >= 2) xs = {xs[62:0], det_x};
      tick();
    end
  endtask

  task automatic check_job(input string tag, input logic [15:0] d, input logic [4:0] ln,
                           input int start_last);
    int          L;
    int          done_cyc;
    int          lows;
    logic [63:0] xs;
    logic [4:0]  mc;
    logic        b1;
    L = (ln > 5'd16) ? 16 : int'(ln);
    observe(start_last, done_cyc, xs, lows, mc, b1);
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'(L + 3));
    chk({tag, " det_x_stream"}, xs, exp_stream(d, L));
    chk({tag, " match_count"}, 64'(mc), 64'(ref_count(d, L)));
    chk({tag, " det_rst_lows"}, 64'(lows), 64'd1);
    chk({tag, " busy_in_clear"}, 64'(b1), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [15:0] d, input logic [4:0] ln);
    data  = d;
    len   = ln;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_job(tag, d, ln, 0);
    tick();
    chk({tag, " idle_after"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic abort_job(input string tag, input logic [15:0] d, input int at_cycle,
                           input logic [4:0] mc_before);
    int seen;
    data  = d;
    len   = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < at_cycle; c++) tick();
    chk({tag, " count_before"}, 64'(match_count), 64'(mc_before));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, " idle_no_done"}, 64'({busy, done}), 64'd0);
    chk({tag, " count_cleared"}, 64'(match_count), 64'd0);
    chk({tag, " det_rst_low"}, 64'(det_rst_n), 64'd0);
    tick();
    chk({tag, " det_rst_high"}, 64'(det_rst_n), 64'd1);
    seen = 0;
    repeat (20) begin
      if (done || busy) seen++;
      tick();
    end
    chk({tag, " stays_idle"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [4:0]  rl;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    data  = '0;
    len   = '0;

    #2;
    chk("reset_outputs", 64'({busy, done, match_count, det_x, det_rst_n}), 64'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("release_det_rst", 64'({det_rst_n, busy, done}), 64'b100);

    run_job("single", 16'h5000, 5'd5);
    run_job("overlap", 16'h5500, 5'd9);
    run_job("len0", 16'hFFFF, 5'd0);
    run_job("len20", 16'h5555, 5'd20);
    run_job("len16", 16'hA52A, 5'd16);

    abort_job("abort_shift3", 16'h5000, 4, 5'd0);
    abort_job("abort_counted", 16'h5000, 9, 5'd1);

    // start held high while busy with different job parameters must change nothing
    data  = 16'h5000;
    len   = 5'd5;
    start = 1'b1;
    tick();
    data  = 16'hFFFF;
    len   = 5'd20;
    check_job("busy_start", 16'h5000, 5'd5, 7);
    tick();
    chk("busy_start idle_after", 64'({busy, done}), 64'd0);

    // back-to-back: start held through DONE with the second job already presented
    data  = 16'h5000;
    len   = 5'd5;
    start = 1'b1;
    tick();
    data  = 16'h5500;
    len   = 5'd9;
    check_job("b2b_first", 16'h5000, 5'd5, 1000);
    tick();
    start = 1'b0;
    check_job("b2b_second", 16'h5500, 5'd9, 0);
    tick();
    chk("b2b idle_after", 64'({busy, done}), 64'd0);

    // asynchronous reset mid-SHIFT
    data  = 16'hFFFF;
    len   = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset busy_shift", 64'({busy, det_x}), 64'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({busy, done, match_count, det_x, det_rst_n}), 64'd0);
    #20 rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 64'({det_rst_n, busy, done}), 64'b100);
    run_job("after_reset", 16'h4A50, 5'd14);

    for (int i = 0; i < 16; i++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd = 16'h5555 ^ (rd & 16'h0841);
      rl = 5'($urandom_range(0, 20));
      run_job("random", rd, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Job controller for the 01010 Moore sequence detector (`FSM`). It accepts a parallel word and a bit length, and clears the detector. It then shifts the word into the detector MSB-first, one bit per clock, and counts every cycle in which the detector output is high. When the job ends it pulses `done` and presents the match count. The detector stays a separate instance beside this block; this block drives its `x` and `rst_n` and observes its `y`.

## Interface
- `DATA_W`, default 16: width of the job word; also the maximum shift length.
- `CNT_W`, default `$clog2(DATA_W+1)`: width of `len` and `match_count`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: job request; sampled only when `busy`=0.
- `abort`, input, 1: cancels a running job; ignored when `busy`=0.
- `data`, input, `DATA_W`: job word, captured on start acceptance; `data[DATA_W-1]` is sent first.
- `len`, input, `CNT_W`: number of bits to send, captured on start acceptance.
- `busy`, output, 1: high in the CLEAR, SHIFT and DRAIN states.
- `done`, output, 1: one-cycle pulse in the DONE state.
- `match_count`, output, `CNT_W`: number of detections; valid from `done` until the next acceptance.
- `det_x`, output, 1: serial bit to the detector `x` input.
- `det_rst_n`, output, 1: active-low detector reset.
- `det_y`, input, 1: detector output `y`.

## Operation
- FSM states and transitions:
  - IDLE: `start` is accepted → CLEAR.
  - CLEAR: lasts 1 cycle → SHIFT.
  - SHIFT: lasts `len` cycles → DRAIN.
  - DRAIN: lasts 1 cycle → DONE.
  - DONE: lasts 1 cycle → IDLE.
- Start acceptance:
  - `start` is accepted in IDLE or DONE.
  - Acceptance captures `data` into a shift register and `min(len, DATA_W)` into a bit counter.
  - Acceptance clears `match_count` to 0.
  - `start` while `busy`=1 is ignored; it is neither queued nor flagged.
  - `start` in the DONE cycle is accepted; the next state is CLEAR, and `done` still pulses in that cycle.
- CLEAR: `det_rst_n` = 0 for exactly this cycle. `det_rst_n` is registered and never glitches.
- SHIFT:
  - `det_x` = shift register MSB; the register shifts left, zero-filled, on each edge.
  - The counter decrements on each edge.
  - Exit to DRAIN occurs when the counter reaches 0.
- `len` = 0: SHIFT is skipped (CLEAR → DRAIN), and the job ends with `match_count` = 0.
- `len` > `DATA_W`: clamped to `DATA_W`.
- Counting:
  - `match_count` increments in every SHIFT or DRAIN cycle in which `det_y` = 1.
  - DRAIN exists because the detector is Moore: the match caused by the last bit is visible only one cycle after that bit.
- `det_x` = 0 outside SHIFT.
- `abort`:
  - In CLEAR, SHIFT or DRAIN, the next state is IDLE, with no `done` pulse.
  - `match_count` is cleared to 0.
  - `det_rst_n` is pulsed low for 1 cycle, in the first IDLE cycle.
  - `abort` has priority over normal progression.
- Counter width: `CNT_W` cannot overflow, because there is at most 1 match per bit.

## Timing
- Reset values while `rst_n`=0: state IDLE, `busy` 0, `done` 0, `match_count` 0, `det_x` 0, `det_rst_n` 0 (the detector is held in reset). `det_rst_n` = 1 in the first cycle after release.
- Cycle numbering, with `start` sampled at edge 0:
  - CLEAR occupies cycle 1.
  - SHIFT occupies cycles 2 .. `len`+1; bit k (0-based) is on `det_x` in cycle k+2.
  - DRAIN occupies cycle `len`+2.
  - `done` = 1 in cycle `len`+3.
- Throughput: back-to-back jobs cost `len`+3 cycles each when `start` is held through DONE.
- `busy` and `done` are registered (state-decoded); `match_count` is registered.
- Asynchronous reset mid-job returns every output to its reset values immediately.

## Structure
- Shared package `fsm_ctrl_pkg` holds:
  - the state encoding localparams (IDLE, CLEAR, SHIFT, DRAIN, DONE; 3 bits);
  - the default `DATA_W`;
  - the detector pattern constant `5'b01010` for bench use.
- One natural sub-module: `piso_shift`, a parallel-in/serial-out MSB-first register with load, shift and zero-fill.
- The testbench instantiates `pattern_scan_ctrl`, `FSM` and the glue wiring.

## Test plan
- Single match: `DATA_W`=16, `data`=16'h5000 (01010 MSB-first), `len`=5 → `det_x` sequence 0,1,0,1,0; `done` at cycle 8 with `match_count`=1; `det_rst_n` low in cycle 1 only.
- Overlap: `data`=16'h5500 (010101010), `len`=9 → `match_count`=3, `done` at cycle 12.
- Boundaries:
  - `len`=0 → `done` at cycle 3, `match_count`=0, `det_x` stays 0.
  - `len`=20 → clamped to 16, `done` at cycle 19.
- Abort and busy `start`:
  - `abort` in the 3rd SHIFT cycle → IDLE next cycle, no `done`, `match_count`=0, one `det_rst_n` low pulse.
  - `start` while busy is ignored.
- Back-to-back: `start` held high through DONE with a new `data` → second CLEAR immediately follows DONE; the first `done` pulses once, and the second job count is independent.
- Reset: `rst_n` low in mid-SHIFT → `busy`, `done`, `match_count`, `det_x` and `det_rst_n` all 0 at once; after release, a clean job completes correctly.
